// File: rtl/fmint_drain_pkg.sv
// Shared types and constants for the FMINT drain path.
package fmint_drain_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FINISHED} drain_state_t;
  localparam int MA_W             = 32;
  localparam int DRAIN_FIFO_DEPTH = 2;
endpackage

// File: rtl/fmint_drain_if.sv
// Main-memory side of the drain: row write-request channel plus pixel write channel.
interface fmint_drain_if import fmint_drain_pkg::*; #(
  parameter int PX_W = 16
) ();
  logic            req_valid;
  logic            req_ready;
  logic [MA_W-1:0] req_addr;
  logic [7:0]      req_len;
  logic            wvalid;
  logic            wready;
  logic [PX_W-1:0] wdata;
  logic            wlast;

  modport master (output req_valid, req_addr, req_len, wvalid, wdata, wlast,
                  input  req_ready, wready);
  modport slave  (input  req_valid, req_addr, req_len, wvalid, wdata, wlast,
                  output req_ready, wready);
endinterface

// File: rtl/fmint_skid_fifo.sv
// Small prefetch FIFO between the FMINT read port and the write channel.
module fmint_skid_fifo import fmint_drain_pkg::*; #(
  parameter int PX_W = 16,
  localparam int CW = $clog2(DRAIN_FIFO_DEPTH + 1),
  localparam int PW = $clog2(DRAIN_FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PX_W-1:0] i_din,
  output logic [PX_W-1:0] o_head,
  output logic [CW-1:0]   o_count
);
  logic [PX_W-1:0] r_mem [DRAIN_FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DRAIN_FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/fmint_drain.sv
// Streams one FMINT tile to main memory: one address request per row, then the row's pixels.
module fmint_drain import fmint_drain_pkg::*; #(
  parameter int PX_W         = 16,
  parameter int TIX          = 4,
  parameter int TIY          = 2,
  parameter int NCH          = 2,
  parameter int FMINT_N_ELEM = 16,
  localparam int AW = (FMINT_N_ELEM > 1) ? $clog2(FMINT_N_ELEM) : 1,
  localparam int CW = $clog2(DRAIN_FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [MA_W-1:0] i_base_addr,
  input  logic [MA_W-1:0] i_ch_stride,
  input  logic [MA_W-1:0] i_row_stride,
  output logic [AW-1:0]   o_fmint_addr,
  output logic            o_fmint_rd,
  input  logic [PX_W-1:0] i_fmint_data,
  fmint_drain_if.master   mif,
  output logic            o_busy,
  output logic            o_finish
);
  drain_state_t    r_state, w_next;
  logic [MA_W-1:0] r_ch_stride, r_row_stride, r_ch_acc, r_row_acc;
  logic [AW-1:0]   r_fm_base;
  logic [8:0]      r_rx, r_bx;
  logic [15:0]     r_f, r_y;
  logic            r_inflight;
  logic [PX_W-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic [2:0]      w_credit;
  logic            w_wvalid, w_pop, w_rd, w_beat_last, w_row_done, w_last_row;

  fmint_skid_fifo #(.PX_W(PX_W)) u_fifo (
    .clk(clk), .rst(rst), .i_push(r_inflight), .i_pop(w_pop),
    .i_din(i_fmint_data), .o_head(w_head), .o_count(w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_wvalid    = (r_state == DATA) && (w_count != '0);
    w_pop       = w_wvalid && mif.wready;
    w_beat_last = (r_bx == 9'(TIX - 1));
    w_row_done  = w_pop && w_beat_last;
    w_last_row  = (r_y == 16'(TIY - 1)) && (r_f == 16'(NCH - 1));
    // Reads in flight count against FIFO space so a returning pixel always has a slot.
    w_credit    = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    w_rd        = (r_state == DATA) && (r_rx < 9'(TIX)) && (w_credit < 3'(DRAIN_FIFO_DEPTH));
    unique case (r_state)
      IDLE:     if (i_start) w_next = ADDR;
      ADDR:     if (mif.req_ready) w_next = DATA;
      DATA:     if (w_row_done) w_next = w_last_row ? FINISHED : ADDR;
      FINISHED: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
    mif.req_valid = (r_state == ADDR);
    mif.req_addr  = (r_state == ADDR) ? r_row_acc : '0;
    mif.req_len   = (r_state == ADDR) ? 8'(TIX - 1) : 8'd0;
    mif.wvalid    = w_wvalid;
    mif.wdata     = w_head;
    mif.wlast     = w_wvalid && w_beat_last;
    o_fmint_rd    = w_rd;
    o_fmint_addr  = r_fm_base + AW'(r_rx);
    o_busy        = (r_state != IDLE);
    o_finish      = (r_state == FINISHED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_stride  <= '0;
      r_row_stride <= '0;
      r_ch_acc     <= '0;
      r_row_acc    <= '0;
      r_fm_base    <= '0;
      r_rx         <= '0;
      r_bx         <= '0;
      r_f          <= '0;
      r_y          <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (r_state == IDLE && i_start) begin
        r_ch_stride  <= i_ch_stride;
        r_row_stride <= i_row_stride;
        r_ch_acc     <= i_base_addr;
        r_row_acc    <= i_base_addr;
        r_fm_base    <= '0;
        r_rx         <= '0;
        r_bx         <= '0;
        r_f          <= '0;
        r_y          <= '0;
      end
      if (w_rd) r_rx <= r_rx + 9'd1;
      if (w_pop) r_bx <= r_bx + 9'd1;
      // End of row: channel rows are contiguous in FMINT, so the row base always steps by TIX.
      if (w_row_done) begin
        r_bx      <= '0;
        r_rx      <= '0;
        r_fm_base <= r_fm_base + AW'(TIX);
        if (r_y == 16'(TIY - 1)) begin
          r_y       <= '0;
          r_f       <= r_f + 16'd1;
          r_ch_acc  <= r_ch_acc + r_ch_stride;
          r_row_acc <= r_ch_acc + r_ch_stride;
        end else begin
          r_y       <= r_y + 16'd1;
          r_row_acc <= r_row_acc + r_row_stride;
        end
      end
    end
  end
endmodule

// File: tb/tb_fmint_drain.sv
// Bench for fmint_drain: a 4x2x2 tile instance and a 1x2x1 instance against a tile-order model.
module tb_fmint_drain;
  localparam int TIX_A = 4, TIY_A = 2, NCH_A = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        startA, startB;
  logic [31:0] baseA, csA, rsA, baseB, csB, rsB;
  logic [3:0]  fmaA, fmaB;
  logic        fmrA, fmrB, busyA, busyB, finA, finB;
  logic [15:0] fmdA, fmdB;

  fmint_drain_if #(.PX_W(16)) ifa ();
  fmint_drain_if #(.PX_W(16)) ifb ();

  fmint_drain #(.PX_W(16), .TIX(TIX_A), .TIY(TIY_A), .NCH(NCH_A), .FMINT_N_ELEM(16)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(startA), .i_base_addr(baseA), .i_ch_stride(csA),
    .i_row_stride(rsA), .o_fmint_addr(fmaA), .o_fmint_rd(fmrA), .i_fmint_data(fmdA),
    .mif(ifa), .o_busy(busyA), .o_finish(finA));

  fmint_drain #(.PX_W(16), .TIX(1), .TIY(2), .NCH(1), .FMINT_N_ELEM(16)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(startB), .i_base_addr(baseB), .i_ch_stride(csB),
    .i_row_stride(rsB), .o_fmint_addr(fmaB), .o_fmint_rd(fmrB), .i_fmint_data(fmdB),
    .mif(ifb), .o_busy(busyB), .o_finish(finB));

  // FMINT model: each word holds its own address, returned one cycle after the read.
  always @(posedge clk) fmdA <= fmrA ? 16'(fmaA) : 16'hDEAD;
  always @(posedge clk) fmdB <= fmrB ? 16'(fmaB) : 16'hDEAD;

  int nvec = 0, nerr = 0, cyc = 0, rmode = 0;
  int drv_st = 0, drv_wl = 0;
  bit drv_ph = 1'b0;

  logic [31:0] rq_a[$], rq_b[$];
  logic [7:0]  rl_a[$], rl_b[$];
  logic [15:0] bq_a[$], bq_b[$];
  logic        lq_a[$], lq_b[$];
  int          rc_a[$], bc_a[$], fq_a[$], fq_b[$];

  int          err_a = 0, out_a = 0;
  logic        pw_stall = 1'b0, pw_last = 1'b0, pr_stall = 1'b0;
  logic [15:0] pw_data = '0;
  logic [31:0] pr_addr = '0;
  logic [7:0]  pr_len = '0;

  always @(negedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      out_a <= 0; pw_stall <= 1'b0; pr_stall <= 1'b0;
    end else begin
      if (ifa.req_valid && ifa.req_ready) begin
        rq_a.push_back(ifa.req_addr); rl_a.push_back(ifa.req_len); rc_a.push_back(cyc);
      end
      if (ifa.wvalid && ifa.wready) begin
        bq_a.push_back(ifa.wdata); lq_a.push_back(ifa.wlast); bc_a.push_back(cyc);
      end
      if (finA) fq_a.push_back(cyc);
      err_a <= err_a
        + int'(pw_stall && !(ifa.wvalid && ifa.wdata == pw_data && ifa.wlast == pw_last))
        + int'(pr_stall && !(ifa.req_valid && ifa.req_addr == pr_addr && ifa.req_len == pr_len))
        + int'(ifa.req_valid && fmrA)
        + int'(finA && !busyA)
        + int'((out_a + int'(fmrA) - int'(ifa.wvalid && ifa.wready)) > 2);
      out_a    <= out_a + int'(fmrA) - int'(ifa.wvalid && ifa.wready);
      pw_stall <= ifa.wvalid && !ifa.wready;
      pw_data  <= ifa.wdata;
      pw_last  <= ifa.wlast;
      pr_stall <= ifa.req_valid && !ifa.req_ready;
      pr_addr  <= ifa.req_addr;
      pr_len   <= ifa.req_len;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ifb.req_valid && ifb.req_ready) begin rq_b.push_back(ifb.req_addr); rl_b.push_back(ifb.req_len); end
      if (ifb.wvalid && ifb.wready) begin bq_b.push_back(ifb.wdata); lq_b.push_back(ifb.wlast); end
      if (finB) fq_b.push_back(cyc);
    end
  end

  // Ready patterns for instance A.
  initial begin
    ifa.req_ready = 1'b1;
    ifa.wready    = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rq_a.size() == 0) drv_st = 0;
      if (bq_a.size() == 0) drv_wl = 0;
      drv_ph = !drv_ph;
      ifa.req_ready = 1'b1;
      ifa.wready    = 1'b1;
      case (rmode)
        1: ifa.wready = drv_ph;
        2: begin
          ifa.req_ready = ($urandom_range(0, 1) == 1);
          ifa.wready    = ($urandom_range(0, 2) != 0);
        end
        3: if (ifa.req_valid && rq_a.size() == 1 && drv_st < 5) begin
          ifa.req_ready = 1'b0; drv_st++;
        end
        4: if (bq_a.size() == 5 && drv_wl < 6) begin
          ifa.wready = 1'b0; drv_wl++;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    rq_a.delete(); rl_a.delete(); bq_a.delete(); lq_a.delete();
    rc_a.delete(); bc_a.delete(); fq_a.delete();
  endtask

  task automatic drain(input logic [31:0] b, input logic [31:0] cs, input logic [31:0] rs,
                       input int mode, input bit mid, input bit tim);
    int  e0;
    bit  ok;
    logic [31:0] ea;
    clear_a();
    e0 = err_a;
    rmode = mode; baseA = b; csA = cs; rsA = rs;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk); #1;
      startA = mid && (bq_a.size() == 5);
      ok = (fq_a.size() != 0);
    end
    startA = 1'b0;
    check("finish_seen", 64'(ok), 64'd1);
    check("idle_after_finish", {busyA, finA}, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    check("finish_once", fq_a.size(), 1);
    check("req_count", rq_a.size(), NCH_A * TIY_A);
    for (int f = 0; f < NCH_A; f++)
      for (int y = 0; y < TIY_A; y++)
        if (f * TIY_A + y < rq_a.size()) begin
          ea = b + 32'(f) * cs + 32'(y) * rs;
          check("req_addr", rq_a[f * TIY_A + y], ea);
          check("req_len", rl_a[f * TIY_A + y], TIX_A - 1);
        end
    check("beat_count", bq_a.size(), NCH_A * TIY_A * TIX_A);
    for (int i = 0; i < bq_a.size(); i++) begin
      check("wdata", bq_a[i], i);
      check("wlast", lq_a[i], (i % TIX_A) == TIX_A - 1);
    end
    if (bc_a.size() > 0 && fq_a.size() > 0) check("finish_after_last", fq_a[0] - bc_a[$], 1);
    check("protocol_errors", err_a - e0, 0);
    if (mode == 3 && rc_a.size() > 1) check("req_stall_gap", rc_a[1] - rc_a[0], TIX_A + 3 + 5);
    if (tim && rc_a.size() > 0 && bc_a.size() > 0 && fq_a.size() > 0) begin
      check("first_beat_latency", bc_a[0] - rc_a[0], 3);
      check("drain_cycles", fq_a[0] - rc_a[0], NCH_A * TIY_A * (TIX_A + 3));
    end
  endtask

  initial begin
    bit ok;
    rst = 1'b1; startA = 1'b0; startB = 1'b0;
    baseA = '0; csA = '0; rsA = '0; baseB = '0; csB = '0; rsB = '0;
    ifb.req_ready = 1'b1; ifb.wready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_a", {ifa.req_valid, ifa.req_addr, ifa.req_len}, '0);
    check("rst_w_a", {ifa.wvalid, ifa.wdata, ifa.wlast}, '0);
    check("rst_ctl_a", {fmrA, fmaA, busyA, finA}, '0);
    check("rst_req_b", {ifb.req_valid, ifb.req_addr, ifb.req_len}, '0);
    check("rst_w_b", {ifb.wvalid, ifb.wdata, ifb.wlast}, '0);
    check("rst_ctl_b", {fmrB, fmaB, busyB, finB}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    drain(32'h100, 32'h40, 32'h10, 0, 1'b0, 1'b1);
    drain(32'h100, 32'h40, 32'h10, 1, 1'b0, 1'b0);
    drain(32'h100, 32'h40, 32'h10, 4, 1'b0, 1'b0);
    drain(32'h100, 32'h40, 32'h10, 3, 1'b0, 1'b0);
    drain(32'h100, 32'h40, 32'h10, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drain($urandom, $urandom, $urandom, 2, 1'b0, 1'b0);
    drain(32'hFFFF_FFF0, 32'h20, 32'h8, 2, 1'b0, 1'b0);

    // Abort in the middle of beat 6, then a clean restart.
    clear_a();
    rmode = 0; baseA = 32'h100; csA = 32'h40; rsA = 32'h10;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      ok = (bq_a.size() == 6);
    end
    check("reach_beat6", 64'(ok), 64'd1);
    check("beat6_live", {ifa.wvalid, ifa.wdata}, {1'b1, 16'd6});
    rst = 1'b1;
    #1;
    check("abort_req", {ifa.req_valid, ifa.req_addr, ifa.req_len}, '0);
    check("abort_w", {ifa.wvalid, ifa.wdata, ifa.wlast}, '0);
    check("abort_ctl", {fmrA, fmaA, busyA, finA}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drain(32'h100, 32'h40, 32'h10, 0, 1'b0, 1'b1);

    // Single-column tile on instance B.
    baseB = $urandom; csB = $urandom; rsB = $urandom;
    rq_b.delete(); rl_b.delete(); bq_b.delete(); lq_b.delete(); fq_b.delete();
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      ok = (fq_b.size() != 0);
    end
    check("b_finish_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b_finish_once", fq_b.size(), 1);
    check("b_req_count", rq_b.size(), 2);
    check("b_beat_count", bq_b.size(), 2);
    for (int y = 0; y < 2; y++) begin
      if (y < rq_b.size()) begin
        check("b_req_addr", rq_b[y], baseB + 32'(y) * rsB);
        check("b_req_len", rl_b[y], 0);
      end
      if (y < bq_b.size()) begin
        check("b_wdata", bq_b[y], y);
        check("b_wlast", lq_b[y], 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
